id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the five-stage RISC-V core. It sits directly downstream of the main decoder (`control`) and register file. It registers the decoder's control bundle, operands and register indices into the execute stage. It also detects load-use hazards, inserting a one-cycle bubble and stalling the front end, and it honours branch flush and downstream hold.

## Interface
- XLEN, 32, datapath width
- REG_AW, 5, register index width

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID holds a real instruction
- id_pc_i  in  XLEN  instruction PC
- id_rs1_i, id_rs2_i, id_rd_i  in  REG_AW  register indices
- id_rs1_data_i, id_rs2_data_i, id_imm_i  in  XLEN  operands, immediate
- id_funct_i  in  4  {funct7[5], funct3}
- alu_src_i, mem2reg_i, reg_write_i, mem_read_i, mem_write_i, branch_i  in  1 each  decoder controls
- alu_op_i  in  2  decoder ALU_op
- flush_i  in  1  taken branch from EX; kill stage contents
- hold_i  in  1  downstream (MEM) busy; freeze stage
- stall_o  out  1  combinational; PC and IF/ID must hold
- ex_valid_o, ex_pc_o, ex_rs1_o, ex_rs2_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_funct_o  out  as inputs  registered copies
- ex_alu_src_o, ex_mem2reg_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_alu_op_o  out  as inputs  registered controls

## Operation
- hazard = id_valid_i & ex_valid_o & ex_mem_read_o & (ex_rd_o != 0) & ((ex_rd_o == id_rs1_i) | (uses_rs2 & ex_rd_o == id_rs2_i)).
- uses_rs2 = ~alu_src_i | mem_write_i.
- stall_o = (hazard | hold_i) & ~flush_i.
- Per rising edge, first matching rule wins:
  1. flush_i: ex_valid_o and all ex_ controls <= 0; data fields don't-care (hold).
  2. hold_i: every register keeps its value.
  3. hazard: bubble — ex_valid_o and controls <= 0; data fields hold.
  4. otherwise load: ex_valid_o <= id_valid_i; data fields <= inputs; controls <= input & id_valid_i.
- Sanitising: ex_mem2reg_o <= mem2reg_i & reg_write_i & id_valid_i, so a don't-care mem2reg on store/branch never reaches EX.
- Bubble lasts exactly one cycle: after it ex_valid_o=0, so hazard deasserts and the held instruction loads next edge.
- Load from x0 (ex_rd_o=0) never stalls.

## Timing
- Latency ID->EX: 1 cycle.
- Reset (rst_n low, async): all ex_ outputs 0, counters 0. stall_o follows its equation (0 once ex_valid_o=0).
- Reset released mid-operation: first edge after release performs a normal load.
- flush_i with hazard or hold_i the same cycle: flush wins, stall_o=0.
- hold_i with hazard: hold wins; the bubble is inserted on the first non-hold edge if the hazard persists.
- stall_o is combinational from ID inputs and ex_ registers; no registered path to IF.

## Configuration
- ID_EX_PERF_EN defined: adds outputs bubble_cnt_o[31:0] and flush_cnt_o[31:0].
  - bubble_cnt_o increments on every edge taking rule 3.
  - flush_cnt_o increments on every edge with flush_i=1.
  - Both saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: ports and counters absent; functional behaviour identical.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants (R_TYPE, LOAD, STORE, BRANCH)
  - ALU_op encodings: 00 add, 01 compare/sub, 10 funct-decoded
  - ctrl_t struct bundling the seven decoder controls, used for the ex_ control register
- One sub-module: id_ex_hazard, purely combinational, producing hazard and uses_rs2.

## Test plan
- R-type add (rd=5, rs1=1, rs2=2, reg_write=1, alu_op=10), no stall -> next cycle ex_valid_o=1, ex_rd_o=5, ex_alu_op_o=10, stall_o=0.
- LOAD rd=7, then R-type rs2=7 -> stall_o=1 for one cycle, one bubble (ex_valid_o=0), R-type appears in EX on the following cycle.
- LOAD rd=0, then R-type rs1=0 -> no stall; LOAD rd=3, then I-type (alu_src=1) rs2 field=3 -> no stall.
- Hazard with flush_i=1 in the same cycle -> stall_o=0, ex_valid_o=0 next cycle, all ex_ controls 0.
- hold_i=1 for 3 cycles with a valid instruction in EX -> all ex_ outputs unchanged, stall_o=1 throughout.
- STORE with mem2reg_i=1 -> ex_mem2reg_o=0. With ID_EX_PERF_EN, two load-use bubbles -> bubble_cnt_o=2. Assert rst_n low mid-run -> all outputs 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: opcodes, ALU_op encodings and the decoder control bundle.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_CMP   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       alu_src;
    logic       mem2reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // Gate controls with the valid bit; mem2reg only survives when the result is actually written.
  function automatic ctrl_t sanitise_ctrl(input ctrl_t c, input logic valid);
    ctrl_t r;
    r.alu_src   = c.alu_src & valid;
    r.mem2reg   = c.mem2reg & c.reg_write & valid;
    r.reg_write = c.reg_write & valid;
    r.mem_read  = c.mem_read & valid;
    r.mem_write = c.mem_write & valid;
    r.branch    = c.branch & valid;
    r.alu_op    = c.alu_op & {2{valid}};
    return r;
  endfunction

endpackage

// File: rtl/id_ex_hazard.sv
// Combinational load-use hazard detector between the instruction in ID and a load in EX.
module id_ex_hazard
  import riscv_pkg::*;
(
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              alu_src,
  input  logic              mem_write,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              hazard
);

  logic uses_rs2_s;
  logic rs1_match_s;
  logic rs2_match_s;

  // rs2 is a real source for register-register ops and as store data.
  assign uses_rs2_s  = ~alu_src | mem_write;
  assign rs1_match_s = (ex_rd == id_rs1);
  assign rs2_match_s = uses_rs2_s & (ex_rd == id_rs2);
  assign hazard      = id_valid & ex_valid & ex_mem_read & (ex_rd != {REG_AW{1'b0}})
                     & (rs1_match_s | rs2_match_s);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, flush and hold handling.
// Optional ID_EX_PERF_EN adds saturating bubble and flush counters.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [XLEN-1:0]   id_rs1_data_i,
  input  logic [XLEN-1:0]   id_rs2_data_i,
  input  logic [XLEN-1:0]   id_imm_i,
  input  logic [3:0]        id_funct_i,
  input  logic              alu_src_i,
  input  logic              mem2reg_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              branch_i,
  input  logic [1:0]        alu_op_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [XLEN-1:0]   ex_rs2_data_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic [3:0]        ex_funct_o,
  output logic              ex_alu_src_o,
  output logic              ex_mem2reg_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_branch_o,
  output logic [1:0]        ex_alu_op_o
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]       bubble_cnt_o,
  output logic [31:0]       flush_cnt_o
`endif
);

  logic              ex_valid_r;
  ctrl_t             ctrl_r;
  ctrl_t             ctrl_in_s;
  logic [XLEN-1:0]   pc_r, rs1_data_r, rs2_data_r, imm_r;
  logic [REG_AW-1:0] rs1_r, rs2_r, rd_r;
  logic [3:0]        funct_r;
  logic              hazard_s;
  logic              load_s;

  assign ctrl_in_s = '{alu_src: alu_src_i, mem2reg: mem2reg_i, reg_write: reg_write_i,
                       mem_read: mem_read_i, mem_write: mem_write_i, branch: branch_i,
                       alu_op: alu_op_i};

  id_ex_hazard u_hazard (
    .id_valid    (id_valid_i),
    .id_rs1      (id_rs1_i),
    .id_rs2      (id_rs2_i),
    .alu_src     (alu_src_i),
    .mem_write   (mem_write_i),
    .ex_valid    (ex_valid_r),
    .ex_mem_read (ctrl_r.mem_read),
    .ex_rd       (rd_r),
    .hazard      (hazard_s)
  );

  assign stall_o = (hazard_s | hold_i) & ~flush_i;
  assign load_s  = ~flush_i & ~hold_i & ~hazard_s;

  // Valid/control register: flush, then hold, then bubble, then load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r <= 1'b0;
      ctrl_r     <= '0;
    end else if (flush_i) begin
      ex_valid_r <= 1'b0;
      ctrl_r     <= '0;
    end else if (hold_i) begin
      ex_valid_r <= ex_valid_r;
      ctrl_r     <= ctrl_r;
    end else if (hazard_s) begin
      ex_valid_r <= 1'b0;
      ctrl_r     <= '0;
    end else begin
      ex_valid_r <= id_valid_i;
      ctrl_r     <= sanitise_ctrl(ctrl_in_s, id_valid_i);
    end
  end

  // Data fields only move on a normal load; otherwise they hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= {XLEN{1'b0}};
      rs1_data_r <= {XLEN{1'b0}};
      rs2_data_r <= {XLEN{1'b0}};
      imm_r      <= {XLEN{1'b0}};
      rs1_r      <= {REG_AW{1'b0}};
      rs2_r      <= {REG_AW{1'b0}};
      rd_r       <= {REG_AW{1'b0}};
      funct_r    <= 4'd0;
    end else if (load_s) begin
      pc_r       <= id_pc_i;
      rs1_data_r <= id_rs1_data_i;
      rs2_data_r <= id_rs2_data_i;
      imm_r      <= id_imm_i;
      rs1_r      <= id_rs1_i;
      rs2_r      <= id_rs2_i;
      rd_r       <= id_rd_i;
      funct_r    <= id_funct_i;
    end else begin
      pc_r       <= pc_r;
      rs1_data_r <= rs1_data_r;
      rs2_data_r <= rs2_data_r;
      imm_r      <= imm_r;
      rs1_r      <= rs1_r;
      rs2_r      <= rs2_r;
      rd_r       <= rd_r;
      funct_r    <= funct_r;
    end
  end

  assign ex_valid_o     = ex_valid_r;
  assign ex_pc_o        = pc_r;
  assign ex_rs1_o       = rs1_r;
  assign ex_rs2_o       = rs2_r;
  assign ex_rd_o        = rd_r;
  assign ex_rs1_data_o  = rs1_data_r;
  assign ex_rs2_data_o  = rs2_data_r;
  assign ex_imm_o       = imm_r;
  assign ex_funct_o     = funct_r;
  assign ex_alu_src_o   = ctrl_r.alu_src;
  assign ex_mem2reg_o   = ctrl_r.mem2reg;
  assign ex_reg_write_o = ctrl_r.reg_write;
  assign ex_mem_read_o  = ctrl_r.mem_read;
  assign ex_mem_write_o = ctrl_r.mem_write;
  assign ex_branch_o    = ctrl_r.branch;
  assign ex_alu_op_o    = ctrl_r.alu_op;

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_r;
  logic [31:0] flush_cnt_r;
  logic        bubble_en_s;

  assign bubble_en_s = ~flush_i & ~hold_i & hazard_s;

  // Saturating event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_r <= 32'd0;
      flush_cnt_r  <= 32'd0;
    end else begin
      if (bubble_en_s && (bubble_cnt_r != 32'hFFFF_FFFF)) begin
        bubble_cnt_r <= bubble_cnt_r + 32'd1;
      end else begin
        bubble_cnt_r <= bubble_cnt_r;
      end
      if (flush_i && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign bubble_cnt_o = bubble_cnt_r;
  assign flush_cnt_o  = flush_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instruction stream, expected EX state queued per issue.
module tb_id_ex_stage;
  import riscv_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1d, rs2d, imm;
    logic [3:0]  funct;
    logic [7:0]  ctrl;
    logic        flush, hold;
  } in_t;

  typedef struct {
    int          step;
    logic        valid;
    logic        chk_data;
    logic [7:0]  ctrl;
    logic [4:0]  rd;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [3:0]  funct;
  } exp_t;

  // ctrl = {alu_src, mem2reg, reg_write, mem_read, mem_write, branch, alu_op[1:0]}
  localparam logic [7:0] C_RADD   = 8'b0010_0010;
  localparam logic [7:0] C_LOAD   = 8'b1111_0000;
  localparam logic [7:0] C_ITYPE  = 8'b1010_0010;
  localparam logic [7:0] C_ST_IN  = 8'b1100_1000;
  localparam logic [7:0] C_ST_EXP = 8'b1000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur;
  int   tests = 0;
  int   fails = 0;
  int   step_no = 0;
  exp_t q[$];

  logic        stall_o, ex_valid_o;
  logic [31:0] ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [3:0]  ex_funct_o;
  logic        ex_alu_src_o, ex_mem2reg_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o;
  logic [1:0]  ex_alu_op_o;
  logic        alu_src_s, mem2reg_s, reg_write_s, mem_read_s, mem_write_s, branch_s;
  logic [1:0]  alu_op_s;
  logic [7:0]  ex_ctrl;
`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_o, flush_cnt_o;
`endif

  assign {alu_src_s, mem2reg_s, reg_write_s, mem_read_s, mem_write_s, branch_s, alu_op_s} = cur.ctrl;
  assign ex_ctrl = {ex_alu_src_o, ex_mem2reg_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
                    ex_branch_o, ex_alu_op_o};

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(cur.valid), .id_pc_i(cur.pc),
    .id_rs1_i(cur.rs1), .id_rs2_i(cur.rs2), .id_rd_i(cur.rd),
    .id_rs1_data_i(cur.rs1d), .id_rs2_data_i(cur.rs2d), .id_imm_i(cur.imm), .id_funct_i(cur.funct),
    .alu_src_i(alu_src_s), .mem2reg_i(mem2reg_s), .reg_write_i(reg_write_s),
    .mem_read_i(mem_read_s), .mem_write_i(mem_write_s), .branch_i(branch_s), .alu_op_i(alu_op_s),
    .flush_i(cur.flush), .hold_i(cur.hold), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o),
    .ex_rd_o(ex_rd_o), .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o),
    .ex_imm_o(ex_imm_o), .ex_funct_o(ex_funct_o),
    .ex_alu_src_o(ex_alu_src_o), .ex_mem2reg_o(ex_mem2reg_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .ex_branch_o(ex_branch_o),
    .ex_alu_op_o(ex_alu_op_o)
`ifdef ID_EX_PERF_EN
    , .bubble_cnt_o(bubble_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h, want %h", nm, step, act, exp);
    end
  endtask

  function automatic in_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [7:0] c);
    in_t v;
    v.valid = 1'b1; v.pc = pc; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.rs1d = pc ^ 32'h5A5A_0000; v.rs2d = pc ^ 32'h0000_A5A5;
    v.imm = {20'd0, pc[11:0]}; v.funct = pc[5:2]; v.ctrl = c;
    v.flush = 1'b0; v.hold = 1'b0;
    return v;
  endfunction

  function automatic exp_t ex_of(input in_t src, input logic valid, input logic [7:0] c, input logic chk_d);
    exp_t e;
    e.step = 0; e.valid = valid; e.chk_data = chk_d; e.ctrl = c; e.rd = src.rd;
    e.pc = src.pc; e.rs1d = src.rs1d; e.rs2d = src.rs2d; e.imm = src.imm; e.funct = src.funct;
    return e;
  endfunction

  task automatic issue(input in_t v, input logic exp_stall, input exp_t e);
    @(negedge clk);
    step_no++;
    cur = v;
    #1;
    chk("stall", step_no, {31'd0, stall_o}, {31'd0, exp_stall});
    e.step = step_no;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
      q.delete();
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_valid"}, step_no, {31'd0, ex_valid_o}, 32'd0);
    chk({nm, "_ctrl"}, step_no, {24'd0, ex_ctrl}, 32'd0);
    chk({nm, "_rd"}, step_no, {27'd0, ex_rd_o}, 32'd0);
    chk({nm, "_pc"}, step_no, ex_pc_o, 32'd0);
    chk({nm, "_rs1d"}, step_no, ex_rs1_data_o, 32'd0);
    chk({nm, "_stall"}, step_no, {31'd0, stall_o}, 32'd0);
`ifdef ID_EX_PERF_EN
    chk({nm, "_bcnt"}, step_no, bubble_cnt_o, 32'd0);
    chk({nm, "_fcnt"}, step_no, flush_cnt_o, 32'd0);
`endif
  endtask

  // Monitor: after each rising edge compare EX state against the oldest expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_valid", e.step, {31'd0, ex_valid_o}, {31'd0, e.valid});
      chk("ex_ctrl", e.step, {24'd0, ex_ctrl}, {24'd0, e.ctrl});
      if (e.chk_data) begin
        chk("ex_rd", e.step, {27'd0, ex_rd_o}, {27'd0, e.rd});
        chk("ex_pc", e.step, ex_pc_o, e.pc);
        chk("ex_rs1_data", e.step, ex_rs1_data_o, e.rs1d);
        chk("ex_rs2_data", e.step, ex_rs2_data_o, e.rs2d);
        chk("ex_imm", e.step, ex_imm_o, e.imm);
        chk("ex_funct", e.step, {28'd0, ex_funct_o}, {28'd0, e.funct});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    in_t a, ld7, r8, ld0, r9, ld3, i10, ld6, r11, ld12, r13, r13h, st, inv;
    cur = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    a    = mk(32'h100, 5'd5, 5'd1, 5'd2, C_RADD);
    ld7  = mk(32'h104, 5'd7, 5'd1, 5'd0, C_LOAD);
    r8   = mk(32'h108, 5'd8, 5'd3, 5'd7, C_RADD);
    ld0  = mk(32'h10C, 5'd0, 5'd2, 5'd0, C_LOAD);
    r9   = mk(32'h110, 5'd9, 5'd0, 5'd4, C_RADD);
    ld3  = mk(32'h114, 5'd3, 5'd1, 5'd0, C_LOAD);
    i10  = mk(32'h118, 5'd10, 5'd4, 5'd3, C_ITYPE);
    ld6  = mk(32'h11C, 5'd6, 5'd1, 5'd0, C_LOAD);
    r11  = mk(32'h120, 5'd11, 5'd6, 5'd2, C_RADD);
    r11.flush = 1'b1;
    ld12 = mk(32'h124, 5'd12, 5'd1, 5'd0, C_LOAD);
    r13  = mk(32'h128, 5'd13, 5'd12, 5'd2, C_RADD);
    r13h = r13;
    r13h.hold = 1'b1;
    st   = mk(32'h12C, 5'd14, 5'd1, 5'd2, C_ST_IN);
    st.ctrl[6] = 1'b1;
    inv  = mk(32'h130, 5'd15, 5'd3, 5'd4, C_RADD);
    inv.valid = 1'b0;

    issue(a,    1'b0, ex_of(a, 1'b1, C_RADD, 1'b1));
    issue(ld7,  1'b0, ex_of(ld7, 1'b1, C_LOAD, 1'b1));
    issue(r8,   1'b1, ex_of(ld7, 1'b0, 8'h00, 1'b1));     // load-use bubble, data holds
    issue(r8,   1'b0, ex_of(r8, 1'b1, C_RADD, 1'b1));
    issue(ld0,  1'b0, ex_of(ld0, 1'b1, C_LOAD, 1'b1));
    issue(r9,   1'b0, ex_of(r9, 1'b1, C_RADD, 1'b1));     // load to x0 never stalls
    issue(ld3,  1'b0, ex_of(ld3, 1'b1, C_LOAD, 1'b1));
    issue(i10,  1'b0, ex_of(i10, 1'b1, C_ITYPE, 1'b1));   // rs2 field unused by I-type
    issue(ld6,  1'b0, ex_of(ld6, 1'b1, C_LOAD, 1'b1));
    issue(r11,  1'b0, ex_of(ld6, 1'b0, 8'h00, 1'b0));     // flush beats hazard
    issue(ld12, 1'b0, ex_of(ld12, 1'b1, C_LOAD, 1'b1));
    for (int i = 0; i < 3; i++) issue(r13h, 1'b1, ex_of(ld12, 1'b1, C_LOAD, 1'b1));
    issue(r13,  1'b1, ex_of(ld12, 1'b0, 8'h00, 1'b1));    // deferred bubble after hold
    issue(r13,  1'b0, ex_of(r13, 1'b1, C_RADD, 1'b1));
    issue(st,   1'b0, ex_of(st, 1'b1, C_ST_EXP, 1'b1));   // mem2reg stripped on store
    issue(inv,  1'b0, ex_of(inv, 1'b0, 8'h00, 1'b1));     // invalid: controls zero, data loads
    drain();
`ifdef ID_EX_PERF_EN
    chk("bubble_cnt", step_no, bubble_cnt_o, 32'd2);
    chk("flush_cnt", step_no, flush_cnt_o, 32'd1);
`endif

    issue(a, 1'b0, ex_of(a, 1'b1, C_RADD, 1'b1));
    drain();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    step_no++;
    begin
      exp_t e;
      e = ex_of(a, 1'b1, C_RADD, 1'b1);
      e.step = step_no;
      q.push_back(e);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
